uart_tx_port: RTL and testbench

UART_TX_PORT -- requirements
Module: uart_tx_port

---
 rtl/uart_tx_port.sv | 135 +++++++++++++
 tb/tb_uart_tx_port.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - memory-mapped UART transmitter with TX FIFO, status register and interrupt
// Frames are 8N1, LSB first; queued bytes go out back-to-back with no idle bit between frames.
module uart_tx_port #(
  parameter int CLK_DIV    = 5208,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        uart_tx,
  output logic        irqout
);
  localparam logic [31:0] TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] CON_ADDR = 32'h4000_0020;
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] CNT_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        push_req, push, pop, ovf_set;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        tick, tx_d, frame_end;
  logic        con_rd, con_wr, busy;
  logic        irq_en, tx_done, ovf;
  logic        unused_wdata;

  assign unused_wdata = ^Write_data[31:8];

  // Pointers carry an extra wrap bit so full and empty differ only in that bit.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign push_req  = MemWrite && (Address == TXD_ADDR);
  assign con_wr    = MemWrite && (Address == CON_ADDR);
  assign con_rd    = MemRead  && (Address == CON_ADDR);
  assign push      = push_req && (!fifo_full || pop);
  assign ovf_set   = push_req && fifo_full && !pop;
  assign tick      = (cnt == CNT_LAST);
  assign frame_end = (state_q == STOP) && tick;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= Write_data[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!fifo_empty) state_d = START;
      START: if (tick) state_d = DATA;
      DATA:  if (tick && bit_idx == 3'd7) state_d = STOP;
      STOP:  if (tick) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop  = 1'b0;
    tx_d = uart_tx;
    case (state_q)
      IDLE: begin
        pop  = !fifo_empty;
        tx_d = fifo_empty;
      end
      START: if (tick) tx_d = shreg[0];
      DATA:  if (tick) tx_d = (bit_idx == 3'd7) ? 1'b1 : shreg[1];
      STOP: begin
        if (tick) begin
          pop  = !fifo_empty;
          tx_d = fifo_empty;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
    end else begin
      uart_tx <= tx_d;
      if (state_q == IDLE || tick) cnt <= '0;
      else                         cnt <= cnt + 16'd1;
      if (state_q != DATA) bit_idx <= '0;
      else if (tick)       bit_idx <= bit_idx + 3'd1;
      if (pop)                          shreg <= mem[rd_ptr[AW-1:0]];
      else if (state_q == DATA && tick) shreg <= {1'b0, shreg[7:1]};
    end
  end

  // A status read clears the sticky flags, but a set in the same cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en  <= 1'b0;
      tx_done <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (con_wr) irq_en <= Write_data[0];
      tx_done <= frame_end | (tx_done & ~con_rd);
      ovf     <= ovf_set   | (ovf & ~con_rd);
    end
  end

  assign irqout    = irq_en & tx_done;
  assign Read_data = con_rd ? {26'b0, ovf, fifo_full, busy, tx_done, 1'b0, irq_en} : 32'h0;

endmodule

// File: tb/tb_uart_tx_port.sv
// tb/tb_uart_tx_port.sv - directed self-checking bench for uart_tx_port (CLK_DIV=4, FIFO_DEPTH=4)
module tb_uart_tx_port;
  localparam logic [31:0] TXD = 32'h4000_0018;
  localparam logic [31:0] CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] Address, Write_data, Read_data;
  logic        uart_tx, irqout;
  int          vectors = 0;
  int          miscompares = 0;

  uart_tx_port #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
    .uart_tx(uart_tx), .irqout(irqout)
  );

  always #5 clk = ~clk;

  // Expected line level at sample i (1..40) of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    int p;
    p = i - 1;
    if (p < 4) return 1'b0;
    else if (p < 36) return b[3'((p - 4) / 4)];
    else return 1'b1;
  endfunction

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    MemWrite = 1'b1; Address = addr; Write_data = data;
    @(negedge clk);
    MemWrite = 1'b0; Address = '0; Write_data = '0;
  endtask

  // Combinational look at CON with no clock edge in between, so nothing clears.
  task automatic peek_con(output logic [31:0] v);
    MemRead = 1'b1; Address = CON;
    #1 v = Read_data;
    MemRead = 1'b0; Address = '0;
  endtask

  task automatic read_con_clear(output logic [31:0] v);
    @(negedge clk);
    MemRead = 1'b1; Address = CON;
    #1 v = Read_data;
    @(negedge clk);
    MemRead = 1'b0; Address = '0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; Write_data = '0;
    repeat (3) @(negedge clk);
    vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx got %b want 1", uart_tx); end
    vectors++; if (irqout !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irqout); end
    peek_con(v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL reset_con got %h want 00000000", v); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL post_reset_tx got %b want 1", uart_tx); end
    peek_con(v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL post_reset_con got %h want 00000000", v); end
  endtask

  task automatic test_frame_55;
    logic [31:0] v;
    bus_write(TXD, 32'h0000_0055);
    vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL f55_pre got %b want 1", uart_tx); end
    for (int i = 1; i <= 41; i++) begin
      @(negedge clk);
      if (i <= 40) begin
        vectors++;
        if (uart_tx !== exp_bit(8'h55, i)) begin
          miscompares++; $display("FAIL f55_tx[%0d] got %b want %b", i, uart_tx, exp_bit(8'h55, i));
        end
      end
      if (i == 40) begin
        peek_con(v);
        vectors++; if (v !== 32'h08) begin miscompares++; $display("FAIL f55_con_stop got %h want 00000008", v); end
      end
      if (i == 41) begin
        peek_con(v);
        vectors++; if (v !== 32'h04) begin miscompares++; $display("FAIL f55_con_done got %h want 00000004", v); end
      end
    end
    read_con_clear(v);
    vectors++; if (v !== 32'h04) begin miscompares++; $display("FAIL f55_read got %h want 00000004", v); end
    peek_con(v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL f55_cleared got %h want 00000000", v); end
  endtask

  task automatic test_irq;
    logic [31:0] v;
    bus_write(CON, 32'hFFFF_FFF1);
    peek_con(v);
    vectors++; if (v !== 32'h01) begin miscompares++; $display("FAIL irq_en_set got %h want 00000001", v); end
    bus_write(TXD, 32'hDEAD_BEA3);
    for (int i = 1; i <= 41; i++) begin
      @(negedge clk);
      if (i <= 40) begin
        vectors++;
        if (uart_tx !== exp_bit(8'hA3, i)) begin
          miscompares++; $display("FAIL irq_tx[%0d] got %b want %b", i, uart_tx, exp_bit(8'hA3, i));
        end
      end
      vectors++;
      if (irqout !== (i == 41)) begin
        miscompares++; $display("FAIL irq_level[%0d] got %b want %b", i, irqout, (i == 41));
      end
    end
    read_con_clear(v);
    vectors++; if (v !== 32'h05) begin miscompares++; $display("FAIL irq_con got %h want 00000005", v); end
    vectors++; if (irqout !== 1'b0) begin miscompares++; $display("FAIL irq_after_read got %b want 0", irqout); end
    bus_write(CON, 32'h0);
    peek_con(v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL irq_en_clr got %h want 00000000", v); end
  endtask

  task automatic test_overflow;
    logic [7:0]  ob [6];
    logic [31:0] v;
    logic        e;
    ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        e = exp_bit(ob[0], k - 1);
        vectors++; if (uart_tx !== e) begin miscompares++; $display("FAIL ovf_tx[%0d] got %b want %b", k - 1, uart_tx, e); end
      end
      MemWrite = 1'b1; Address = TXD; Write_data = {24'hABCDEF, ob[k]};
    end
    @(negedge clk);
    MemWrite = 1'b0; Address = '0; Write_data = '0;
    e = exp_bit(ob[0], 5);
    vectors++; if (uart_tx !== e) begin miscompares++; $display("FAIL ovf_tx[5] got %b want %b", uart_tx, e); end
    peek_con(v);
    vectors++; if (v !== 32'h38) begin miscompares++; $display("FAIL ovf_con_full got %h want 00000038", v); end
    for (int i = 6; i <= 204; i++) begin
      @(negedge clk);
      e = (i <= 200) ? exp_bit(ob[(i - 1) / 40], ((i - 1) % 40) + 1) : 1'b1;
      vectors++; if (uart_tx !== e) begin miscompares++; $display("FAIL ovf_tx[%0d] got %b want %b", i, uart_tx, e); end
    end
    peek_con(v);
    vectors++; if (v !== 32'h24) begin miscompares++; $display("FAIL ovf_con_end got %h want 00000024", v); end
    read_con_clear(v);
    vectors++; if (v !== 32'h24) begin miscompares++; $display("FAIL ovf_read got %h want 00000024", v); end
    peek_con(v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL ovf_cleared got %h want 00000000", v); end
  endtask

  task automatic test_read_race;
    logic [31:0] v;
    bus_write(TXD, 32'h0000_000F);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      vectors++;
      if (uart_tx !== exp_bit(8'h0F, i)) begin
        miscompares++; $display("FAIL race_tx[%0d] got %b want %b", i, uart_tx, exp_bit(8'h0F, i));
      end
    end
    MemRead = 1'b1; Address = CON;
    #1;
    vectors++; if (Read_data !== 32'h08) begin miscompares++; $display("FAIL race_read got %h want 00000008", Read_data); end
    @(negedge clk);
    MemRead = 1'b0; Address = '0;
    peek_con(v);
    vectors++; if (v !== 32'h04) begin miscompares++; $display("FAIL race_after got %h want 00000004", v); end
    @(negedge clk);
    peek_con(v);
    vectors++; if (v !== 32'h04) begin miscompares++; $display("FAIL race_hold got %h want 00000004", v); end
    read_con_clear(v);
    vectors++; if (v !== 32'h04) begin miscompares++; $display("FAIL race_clear got %h want 00000004", v); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] v;
    bus_write(TXD, 32'h0000_0000);
    bus_write(TXD, 32'h0000_00FF);
    repeat (8) @(negedge clk);
    vectors++; if (uart_tx !== 1'b0) begin miscompares++; $display("FAIL mid_inframe got %b want 0", uart_tx); end
    reset = 1'b1;
    #1;
    vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL mid_async_tx got %b want 1", uart_tx); end
    peek_con(v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL mid_async_con got %h want 00000000", v); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL mid_idle_tx[%0d] got %b want 1", i, uart_tx); end
    end
    peek_con(v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL mid_idle_con got %h want 00000000", v); end
  endtask

  task automatic test_unmapped;
    logic [31:0] v;
    bus_write(CON, 32'h0000_0001);
    @(negedge clk);
    MemRead = 1'b1; Address = TXD;
    #1;
    vectors++; if (Read_data !== 32'h0) begin miscompares++; $display("FAIL txd_read got %h want 00000000", Read_data); end
    Address = 32'h4000_0024;
    #1;
    vectors++; if (Read_data !== 32'h0) begin miscompares++; $display("FAIL unmapped_read got %h want 00000000", Read_data); end
    @(negedge clk);
    MemRead = 1'b0; Address = '0;
    bus_write(32'h4000_0024, 32'h0000_00FE);
    bus_write(32'h4000_0019, 32'h0000_0055);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL unmapped_tx[%0d] got %b want 1", i, uart_tx); end
    end
    peek_con(v);
    vectors++; if (v !== 32'h01) begin miscompares++; $display("FAIL unmapped_con got %h want 00000001", v); end
    bus_write(CON, 32'h0);
    peek_con(v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL unmapped_con_clr got %h want 00000000", v); end
  endtask

  initial begin
    test_reset();
    test_frame_55();
    test_irq();
    test_overflow();
    test_read_race();
    test_reset_midframe();
    test_unmapped();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
